// File: rtl/dat_mem_seq.sv
// dat_mem_seq
//   Single-port data memory with a request/done handshake, registered read
//   data and a built-in clear sequencer. After reset, or whenever clr is
//   sampled high, every word is swept to INIT_VAL before traffic is accepted.
//
// Parameters:
//   DW        data word width
//   AW        address width, depth = 2**AW
//   INIT_VAL  value written to every word by the clear sweep
//
// Ports:
//   clk      clock, rising edge
//   reset    synchronous active-high reset, highest priority
//   clr      restart the clear sweep (beats any request on the same edge)
//   req      access request, honoured only while ready=1
//   wr_en    1 = write, 0 = read (qualified by req)
//   addr     word address
//   dat_in   write data
//   ready    high in IDLE, decoded from the state register only
//   done     registered one-cycle pulse per accepted request
//   dat_out  registered read data, holds between reads
module dat_mem_seq #(
    parameter int              DW       = 8,
    parameter int              AW       = 8,
    parameter logic [DW-1:0]   INIT_VAL = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          req,
    input  logic          wr_en,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] dat_in,
    output logic          ready,
    output logic          done,
    output logic [DW-1:0] dat_out
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          done_q, done_d;
    logic [DW-1:0] dat_out_q;

    // Single write port shared by the sweep and by normal writes.
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic          mem_re;

    logic [DW-1:0] core [DEPTH];

    // Next-state and memory-port control. clr outranks both the sweep and
    // any request, so a colliding request is simply dropped.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        done_d    = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = addr;
        mem_wdata = dat_in;
        mem_re    = 1'b0;

        if (clr) begin
            state_d = ST_CLEAR;
            ptr_d   = '0;
        end else if (state_q == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = ptr_q;
            mem_wdata = INIT_VAL;
            ptr_d     = ptr_q + 1'b1;
            // Last word written on this edge: traffic may start next cycle.
            if (ptr_q == '1) begin
                state_d = ST_IDLE;
            end
        end else if (req) begin
            done_d = 1'b1;
            if (wr_en) begin
                mem_we = 1'b1;
            end else begin
                mem_re = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            done_q  <= done_d;
        end
    end

    // Memory array with registered read. Contents are never reset; the
    // sweep initialises them. The output register has a synchronous reset.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            core[mem_waddr] <= mem_wdata;
        end
        if (reset) begin
            dat_out_q <= '0;
        end else if (mem_re) begin
            dat_out_q <= core[addr];
        end
    end

    assign ready   = (state_q == ST_IDLE);
    assign done    = done_q;
    assign dat_out = dat_out_q;

endmodule

// File: tb/tb_dat_mem_seq.sv
// tb_dat_mem_seq
//   Directed and randomized checks of dat_mem_seq (DW=8, AW=8, INIT_VAL=A5)
//   against a transaction-level model: a 256-entry array plus a count of
//   remaining clear edges.
module tb_dat_mem_seq;

    localparam logic [7:0] INIT = 8'hA5;
    localparam int         NW   = 256;

    logic       clk = 1'b0;
    logic       reset, clr, req, wr_en;
    logic [7:0] addr, dat_in;
    logic       ready, done;
    logic [7:0] dat_out;

    dat_mem_seq #(.DW(8), .AW(8), .INIT_VAL(INIT)) dut (
        .clk     (clk),
        .reset   (reset),
        .clr     (clr),
        .req     (req),
        .wr_en   (wr_en),
        .addr    (addr),
        .dat_in  (dat_in),
        .ready   (ready),
        .done    (done),
        .dat_out (dat_out)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [7:0] mem_m [NW];
    logic       clearing_m;
    int         clr_left_m;
    logic       done_m;
    logic [7:0] dout_m;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_clear();
        clearing_m = 1'b1;
        clr_left_m = NW;
        for (int k = 0; k < NW; k++) mem_m[k] = INIT;
    endtask

    // One clock edge: drive inputs, advance the model, compare outputs.
    task automatic step(input logic r, input logic c, input logic q,
                        input logic w, input logic [7:0] a, input logic [7:0] d);
        reset = r; clr = c; req = q; wr_en = w; addr = a; dat_in = d;
        @(posedge clk);
        if (r) begin
            start_clear();
            done_m = 1'b0;
            dout_m = 8'h00;
        end else if (c) begin
            start_clear();
            done_m = 1'b0;
        end else if (clearing_m) begin
            done_m = 1'b0;
            clr_left_m--;
            if (clr_left_m == 0) clearing_m = 1'b0;
        end else if (q) begin
            done_m = 1'b1;
            if (w) mem_m[a] = d;
            else   dout_m = mem_m[a];
        end else begin
            done_m = 1'b0;
        end
        #1;
        $display("rst=%b clr=%b req=%b we=%b addr=%h din=%h -> ready=%b done=%b dout=%h",
                 r, c, q, w, a, d, ready, done, dat_out);
        chk("ready", {7'd0, ready}, {7'd0, !clearing_m});
        chk("done", {7'd0, done}, {7'd0, done_m});
        chk("dat_out", dat_out, dout_m);
    endtask

    initial begin
        int edges;
        clearing_m = 1'b1;
        clr_left_m = NW;
        done_m = 1'b0;
        dout_m = 8'h00;
        reset = 1'b1; clr = 1'b0; req = 1'b0; wr_en = 1'b0; addr = '0; dat_in = '0;

        // Reset for two cycles, then sweep with writes requested throughout.
        step(1, 0, 0, 0, 8'h00, 8'h00);
        step(1, 0, 0, 0, 8'h00, 8'h00);
        edges = 0;
        while (!ready && edges < 1000) begin
            step(0, 0, 1, 1, 8'($urandom), 8'($urandom));
            edges++;
        end
        chk("first_sweep_len", 8'(edges), 8'(NW));

        // Every word reads INIT.
        for (int i = 0; i < NW; i++) step(0, 0, 1, 0, 8'(i), 8'h00);
        step(0, 0, 0, 0, 8'h00, 8'h00);

        // Write then immediate read of the same address.
        step(0, 0, 1, 1, 8'h10, 8'h3C);
        step(0, 0, 1, 0, 8'h10, 8'h00);
        step(0, 0, 0, 0, 8'h00, 8'h00);

        // Back-to-back alternating writes and reads.
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1, 1, 8'(i), 8'($urandom));
            step(0, 0, 1, 0, 8'(i), 8'h00);
        end

        // Random traffic.
        for (int i = 0; i < 300; i++)
            step(0, 0, ($urandom % 4) != 0, $urandom_range(0, 1),
                 8'($urandom_range(0, 31)), 8'($urandom));

        // clr colliding with a write, then a second clr at sweep edge 100.
        step(0, 0, 1, 1, 8'h20, 8'h11);
        step(0, 1, 1, 1, 8'h20, 8'hFF);
        edges = 0;
        repeat (99) begin
            step(0, 0, 0, 0, 8'h00, 8'h00);
            edges++;
        end
        step(0, 1, 0, 0, 8'h00, 8'h00);
        edges++;
        while (!ready && edges < 1000) begin
            step(0, 0, 0, 0, 8'h00, 8'h00);
            edges++;
        end
        chk("clr_sweep_len_lo", 8'(edges), 8'(356));
        chk("clr_sweep_len_hi", 8'(edges >> 8), 8'(356 >> 8));
        step(0, 0, 1, 0, 8'h20, 8'h00);

        // Reset on the edge after a read request.
        step(0, 0, 1, 1, 8'h33, 8'h5A);
        step(0, 0, 1, 0, 8'h33, 8'h00);
        step(1, 0, 1, 0, 8'h33, 8'h00);
        edges = 0;
        while (!ready && edges < 1000) begin
            step(0, 0, 1, 0, 8'h33, 8'h00);
            edges++;
        end
        chk("reset_sweep_len", 8'(edges), 8'(NW));
        step(0, 0, 1, 0, 8'h33, 8'h00);
        step(0, 0, 1, 0, 8'h00, 8'h00);
        step(0, 0, 1, 0, 8'hFF, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dat_mem_seq.md
# dat_mem_seq

Parametrised single-port data memory with a request/done handshake, registered read data and a built-in clear sequencer. It replaces the 8-bit × 256 combinational-read data memory and sits on the processor's load/store path. Every accepted access is acknowledged by a one-cycle `done` pulse. After reset, or on command, the block sweeps every word to a fixed value before it accepts traffic.

## Interface
- `DW`, default 8: data word width in bits.
- `AW`, default 8: address width; depth = 2**AW words.
- `INIT_VAL`, default 0: DW-bit value written to every word by the clear sweep.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high; highest priority.
- `clr`  in  1  restart the clear sweep; sampled every edge.
- `req`  in  1  access request; accepted only when `ready`=1.
- `wr_en`  in  1  1 = write, 0 = read; qualified by `req`.
- `addr`  in  AW  word address.
- `dat_in`  in  DW  write data.
- `ready`  out  1  high in IDLE; combinational from the state register only.
- `done`  out  1  registered; one-cycle pulse per accepted request.
- `dat_out`  out  DW  registered read data; holds its value between reads.

## Operation
- States: CLEAR and IDLE. A clear pointer `ptr` of width AW+1 or AW with a terminal flag.
- Reset: reset=1 at an edge sets the state to CLEAR, `ptr`=0, `done`=0 and `dat_out`=0. `ready` is therefore 0. Memory contents are not reset directly; the sweep initialises them.
- CLEAR: each edge writes INIT_VAL to core[ptr] and increments `ptr`.
  - The edge that writes address 2**AW−1 moves the state to IDLE.
  - `req` is ignored and `done` stays 0 throughout.
- IDLE, accepted request (`req`=1 at an edge):
  - Write: core[addr] <= dat_in. `dat_out` is unchanged.
  - Read: dat_out <= core[addr].
  - In both cases `done`=1 for the following cycle only.
- IDLE, no request: `done`=0 and `dat_out` holds.
- `clr`=1 at an edge, in either state and when reset=0:
  - The state goes to CLEAR and `ptr` goes to 0.
  - Any simultaneous `req` is dropped: no write, no `dat_out` update, no `done`.
  - A `clr` during CLEAR restarts the sweep from address 0.
- Priority: reset > clr > req.
- Reset asserted mid-sweep or mid-access restarts the sweep from 0. A `done` already scheduled is suppressed, because `done` is 0 after the reset edge.
- The clear sweep never modifies `dat_out`.
- `addr` is always in range. No out-of-range handling is needed.

## Timing
- Read latency is 1: a request sampled at edge N gives valid `dat_out` and `done`=1 in cycle N→N+1.
- Write is complete at edge N. A read of the same address accepted at N+1 returns the new data at N+2.
- Throughput is one access per cycle. Back-to-back requests give `done` high continuously, with `dat_out` updating each cycle for reads.
- Clear duration is exactly 2**AW edges after the first edge with reset=0 and clr=0. With AW=8: 256 edges, and `ready` rises after the 256th edge.
- `ready` changes only on clock edges. The handshake is single-cycle; there is no stall or back-pressure in IDLE.

## Test plan
- Reset then sweep (AW=4, INIT_VAL=8'hA5): hold reset 2 cycles, release.
  - `ready`=0 for 16 edges, then 1.
  - Reads of all 16 addresses return 8'hA5, each with a single `done` pulse.
- Write/read (default params): write 8'h3C to 8'h10, then read 8'h10 on the next cycle.
  - `done` is high for 2 consecutive cycles.
  - `dat_out`=8'h3C one cycle after the read request.
  - `dat_out` is unchanged after the write.
- Back-to-back traffic: alternating writes and reads to 8'h00..8'h07 every cycle.
  - Expect 16 consecutive `done` cycles with no gap.
  - Each read returns the data written on the preceding cycle.
- Requests during CLEAR: drive `req`=1 with `wr_en`=1 throughout the sweep.
  - `done` stays 0.
  - After `ready`=1, every address reads INIT_VAL.
- `clr` collision: in IDLE, assert `clr` and a write to 8'h20 (data 8'hFF) on the same edge.
  - No `done`.
  - Sweep restarts and takes 256 edges.
  - Then 8'h20 reads INIT_VAL.
  - A second `clr` at sweep edge 100 extends the total to 100+256 edges.
- Reset mid-operation: assert reset on the edge after a read request.
  - `done`=0 and `dat_out`=0 after the reset edge.
  - Sweep restarts from address 0.
